pll_reset_sequencer: RTL and testbench

//   Sequences the ECP5 EHXPLLL wrapper: holds the PLL in reset after start-up and waits for LOCK.

---
 rtl/pll_seq_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/pll_reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg : state encoding and saturating-increment helper for the
//               PLL reset sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pll_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_seq_state_t;

  // Increment a counter of 'width' bits, sticking at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val == max_v) ? val : val + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : generic single-bit two-flop synchroniser, clears to 0.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer : holds the PLL in reset, waits for a stable LOCK and
//                       releases downstream domains; re-sequences on lock loss.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int STABLE_CYCLES = 64,
  parameter int CNT_W         = 16,
  parameter int STAT_W        = 8
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              i_pll_lock,
  input  logic              i_relock_req,
  output logic              o_pll_rst,
  output logic              o_ready,
  output logic [STAT_W-1:0] o_relock_count,
  output logic [STAT_W-1:0] o_timeout_count,
  output logic [1:0]        o_state
);

  localparam logic [CNT_W-1:0] c_RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  pll_seq_state_t    r_state;
  pll_seq_state_t    w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              w_lock_s;
  logic              w_relock_inc;
  logic              w_timeout_inc;
  logic              r_pll_rst;
  logic              r_ready;
  logic [STAT_W-1:0] r_relock_count;
  logic [STAT_W-1:0] r_timeout_count;

  sync_2ff u_lock_sync (
    .clk (clk25),
    .rst (rst),
    .i_d (i_pll_lock),
    .o_q (w_lock_s)
  );

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_relock_inc  = 1'b0;
    w_timeout_inc = 1'b0;
    if (i_relock_req) begin
      w_next_state = HOLD;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_cnt == c_RST_LAST) begin
            w_next_state = WAIT_LOCK;
            w_next_cnt   = '0;
          end else begin
            w_next_state = HOLD;
            w_next_cnt   = r_cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (w_lock_s) begin
            w_next_state = STABLE;
            w_next_cnt   = '0;
          end else if (r_cnt == c_TO_LAST) begin
            w_next_state  = HOLD;
            w_next_cnt    = '0;
            w_timeout_inc = 1'b1;
          end else begin
            w_next_state = WAIT_LOCK;
            w_next_cnt   = r_cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          // A lock glitch while settling is not counted as a lock loss.
          if (!w_lock_s) begin
            w_next_state = HOLD;
            w_next_cnt   = '0;
          end else if (r_cnt == c_STABLE_LAST) begin
            w_next_state = RUN;
            w_next_cnt   = '0;
          end else begin
            w_next_state = STABLE;
            w_next_cnt   = r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          w_next_cnt = '0;
          if (!w_lock_s) begin
            w_next_state = HOLD;
            w_relock_inc = 1'b1;
          end else begin
            w_next_state = RUN;
          end
        end
        default: begin
          w_next_state = HOLD;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk25) begin
    if (rst) begin
      r_state         <= HOLD;
      r_cnt           <= '0;
      r_pll_rst       <= 1'b1;
      r_ready         <= 1'b0;
      r_relock_count  <= '0;
      r_timeout_count <= '0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_pll_rst <= (w_next_state == HOLD);
      r_ready   <= (w_next_state == RUN);
      if (w_relock_inc)
        r_relock_count <= STAT_W'(sat_inc(32'(r_relock_count), STAT_W));
      if (w_timeout_inc)
        r_timeout_count <= STAT_W'(sat_inc(32'(r_timeout_count), STAT_W));
    end
  end

  assign o_pll_rst       = r_pll_rst;
  assign o_ready         = r_ready;
  assign o_relock_count  = r_relock_count;
  assign o_timeout_count = r_timeout_count;
  assign o_state         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer : directed stimulus, cycle-level behavioural model
//                          and literal checks for the PLL reset sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pll_reset_sequencer;

  localparam int RST_C = 16;
  localparam int TO_C  = 1000;
  localparam int ST_C  = 64;

  logic       clk25      = 1'b0;
  logic       rst        = 1'b1;
  logic       pll_lock   = 1'b0;
  logic       relock_req = 1'b0;

  logic       pll_rst_a, ready_a, pll_rst_b, ready_b;
  logic [7:0] relock_a, timeout_a;
  logic [1:0] relock_b, timeout_b;
  logic [1:0] state_a, state_b;

  int checks   = 0;
  int failures = 0;

  pll_reset_sequencer #(.RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(ST_C),
                        .CNT_W(16), .STAT_W(8)) u_dut (
    .clk25(clk25), .rst(rst), .i_pll_lock(pll_lock), .i_relock_req(relock_req),
    .o_pll_rst(pll_rst_a), .o_ready(ready_a), .o_relock_count(relock_a),
    .o_timeout_count(timeout_a), .o_state(state_a)
  );

  pll_reset_sequencer #(.RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(ST_C),
                        .CNT_W(16), .STAT_W(2)) u_dut_sat (
    .clk25(clk25), .rst(rst), .i_pll_lock(pll_lock), .i_relock_req(relock_req),
    .o_pll_rst(pll_rst_b), .o_ready(ready_b), .o_relock_count(relock_b),
    .o_timeout_count(timeout_b), .o_state(state_b)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  // Model: phase 0=HOLD 1=WAIT_LOCK 2=STABLE 3=RUN, m_time = cycles spent in phase.
  int m_phase, m_time, m_relocks, m_timeouts;
  bit m_valid = 1'b0;
  bit m_sync[$];

  initial forever begin
    bit ls;
    @(posedge clk25);
    if (rst) begin
      m_phase = 0; m_time = 0; m_relocks = 0; m_timeouts = 0;
      m_sync = '{1'b0, 1'b0};
      m_valid = 1'b1;
    end else if (m_valid) begin
      ls = m_sync.pop_front();
      m_sync.push_back(pll_lock);
      if (relock_req) begin
        m_phase = 0; m_time = 0;
      end else if (m_phase == 0) begin
        if (m_time + 1 == RST_C) begin m_phase = 1; m_time = 0; end
        else m_time++;
      end else if (m_phase == 1) begin
        if (ls) begin m_phase = 2; m_time = 0; end
        else if (m_time + 1 == TO_C) begin m_phase = 0; m_time = 0; m_timeouts++; end
        else m_time++;
      end else if (m_phase == 2) begin
        if (!ls) begin m_phase = 0; m_time = 0; end
        else if (m_time + 1 == ST_C) begin m_phase = 3; m_time = 0; end
        else m_time++;
      end else begin
        if (!ls) begin m_phase = 0; m_time = 0; m_relocks++; end
      end
    end
  end

  initial forever begin
    @(negedge clk25);
    if (m_valid) begin
      check("pll_rst", pll_rst_a, m_phase == 0);
      check("ready", ready_a, m_phase == 3);
      check("state", state_a, m_phase);
      check("relock_count", relock_a, sat(m_relocks, 255));
      check("timeout_count", timeout_a, sat(m_timeouts, 255));
      check("sat_state", state_b, m_phase);
      check("sat_relock_count", relock_b, sat(m_relocks, 3));
      check("sat_timeout_count", timeout_b, sat(m_timeouts, 3));
    end
  end

  task automatic apply_reset(input logic lockv);
    @(negedge clk25);
    rst = 1'b1; pll_lock = lockv; relock_req = 1'b0;
    repeat (3) @(negedge clk25);
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    for (int i = 0; i < budget && state_a != s; i++) @(negedge clk25);
    check(name, state_a, s);
  endtask

  initial begin
    int hi, rise, prev, ninc, hi2, k;
    bit rdy_seen;
    int at[5];

    // 1: lock present from the first cycle
    apply_reset(1'b1);
    hi = 0; rise = -1;
    for (int i = 0; i < 200 && rise < 0; i++) begin
      if (pll_rst_a) hi++;
      if (ready_a) rise = i;
      @(negedge clk25);
    end
    check("t1_pll_rst_len", hi, 16);
    check("t1_ready_rise", rise, 81);
    check("t1_relock", relock_a, 0);
    check("t1_timeout", timeout_a, 0);

    // 2 and 6: no lock, five timeouts
    apply_reset(1'b0);
    prev = 0; ninc = 0; hi2 = 0;
    for (int j = 0; j < 5; j++) at[j] = -1;
    for (int i = 0; i <= 5080; i++) begin
      if (int'(timeout_a) != prev) begin
        if (ninc < 5) at[ninc] = i;
        ninc++;
        prev = int'(timeout_a);
      end
      if (i >= 1016 && i < 2032 && pll_rst_a) hi2++;
      @(negedge clk25);
    end
    check("t2_timeout1_at", at[0], 1016);
    check("t2_timeout2_at", at[1], 2032);
    check("t2_timeout3_at", at[2], 3048);
    check("t2_retry_rst_len", hi2, 16);
    check("t2_timeout_final", timeout_a, 5);
    check("t6_timeout_saturated", timeout_b, 3);

    // 5: relock_req coincident with lock loss, then rst in WAIT_LOCK
    pll_lock = 1'b1;
    wait_state(2'd3, 300, "t5_reach_run");
    repeat (5) @(negedge clk25);
    pll_lock = 1'b0;
    repeat (2) @(negedge clk25);
    relock_req = 1'b1;
    @(negedge clk25);
    relock_req = 1'b0;
    check("t5_state_hold", state_a, 0);
    check("t5_relock_unchanged", relock_a, 0);
    check("t5_timeout_kept", timeout_a, 5);
    wait_state(2'd1, 40, "t5_reach_wait");
    repeat (500) @(negedge clk25);
    rst = 1'b1;
    @(negedge clk25);
    check("t5_rst_pll_rst", pll_rst_a, 1);
    check("t5_rst_ready", ready_a, 0);
    check("t5_rst_state", state_a, 0);
    check("t5_rst_timeout", timeout_a, 0);
    check("t5_rst_timeout_sat", timeout_b, 0);
    check("t5_rst_relock", relock_a, 0);

    // 3: single-cycle lock drop in RUN
    pll_lock = 1'b1;
    repeat (2) @(negedge clk25);
    rst = 1'b0;
    wait_state(2'd3, 200, "t3_reach_run");
    repeat (10) @(negedge clk25);
    pll_lock = 1'b0;
    @(negedge clk25);
    pll_lock = 1'b1;
    k = 1;
    while (ready_a && k < 10) begin
      @(negedge clk25);
      k++;
    end
    check("t3_ready_fall_delay", k, 3);
    check("t3_relock_count", relock_a, 1);
    wait_state(2'd3, 200, "t3_rerun");

    // 4: lock glitch during STABLE
    relock_req = 1'b1;
    @(negedge clk25);
    relock_req = 1'b0;
    rdy_seen = 1'b0;
    wait_state(2'd2, 100, "t4_reach_stable");
    repeat (28) begin
      @(negedge clk25);
      if (ready_a) rdy_seen = 1'b1;
    end
    pll_lock = 1'b0;
    @(negedge clk25);
    pll_lock = 1'b1;
    for (int i = 0; i < 10 && state_a != 2'd0; i++) begin
      if (ready_a) rdy_seen = 1'b1;
      @(negedge clk25);
    end
    check("t4_back_to_hold", state_a, 0);
    check("t4_ready_never", rdy_seen, 0);
    check("t4_relock_unchanged", relock_a, 1);
    check("t4_timeout_unchanged", timeout_a, 0);
    wait_state(2'd3, 200, "t4_recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(20000 * 40);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
